neighbour_scanner: RTL



---
 rtl/neighbour_scanner.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/neighbour_scanner.sv
// Game of Life neighbour scanner: loads a board serially, then streams centre + 8 neighbours per cell.
// Optional toroidal wrap-around enabled by defining NEIGHBOUR_WRAP_EN (default: dead border).
module neighbour_scanner #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_cell,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(ROWS)-1:0] out_row,
  output logic [$clog2(COLS)-1:0] out_col,
  output logic                    out_center,
  output logic [7:0]              out_neighbours,
  output logic                    out_last
);

  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned NCELL = ROWS * COLS;
  localparam int unsigned IW    = $clog2(NCELL);

  typedef enum logic {LOAD = 1'b0, SCAN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [NCELL-1:0]  board_q, board_d;
  logic              at_end;
  logic              load_fire;
  logic              scan_fire;
  logic [IW-1:0]     cur_idx;
  logic [7:0]        nbr;

  // Reads board cell (r, c); indices may be one step outside the board.
  function automatic logic cell_at(input logic [NCELL-1:0] b, input int r, input int c);
    int   rr;
    int   cc;
    logic v;
    rr = r;
    cc = c;
    v  = 1'b0;
`ifdef NEIGHBOUR_WRAP_EN
    if (rr < 0) rr = int'(ROWS) - 1;
    else if (rr >= int'(ROWS)) rr = 0;
    if (cc < 0) cc = int'(COLS) - 1;
    else if (cc >= int'(COLS)) cc = 0;
    v = b[IW'(rr * int'(COLS) + cc)];
`else
    if (rr >= 0 && rr < int'(ROWS) && cc >= 0 && cc < int'(COLS))
      v = b[IW'(rr * int'(COLS) + cc)];
`endif
    return v;
  endfunction

  assign at_end    = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
  assign load_fire = in_valid & in_ready;
  assign scan_fire = out_valid & out_ready;
  assign cur_idx   = IW'(int'(row_q) * int'(COLS) + int'(col_q));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic: phase flips on the handshake of the final cell
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_fire && at_end) state_d = SCAN;
      SCAN:    if (scan_fire && at_end) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // FSM outputs, forced low while reset is asserted
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!rst) begin
      case (state_q)
        LOAD:    in_ready  = 1'b1;
        SCAN:    out_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Raster counters and board write
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    board_d = board_q;
    if (load_fire) board_d[cur_idx] = in_cell;
    if (load_fire || scan_fire) begin
      if (at_end) begin
        row_d = '0;
        col_d = '0;
      end else if (col_q == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      board_q <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      board_q <= board_d;
    end
  end

  // Neighbour vector, bit k follows the fixed compass order around (r, c)
  always_comb begin
    nbr[0] = cell_at(board_q, int'(row_q) - 1, int'(col_q) - 1);
    nbr[1] = cell_at(board_q, int'(row_q) - 1, int'(col_q));
    nbr[2] = cell_at(board_q, int'(row_q) - 1, int'(col_q) + 1);
    nbr[3] = cell_at(board_q, int'(row_q),     int'(col_q) - 1);
    nbr[4] = cell_at(board_q, int'(row_q),     int'(col_q) + 1);
    nbr[5] = cell_at(board_q, int'(row_q) + 1, int'(col_q) - 1);
    nbr[6] = cell_at(board_q, int'(row_q) + 1, int'(col_q));
    nbr[7] = cell_at(board_q, int'(row_q) + 1, int'(col_q) + 1);
  end

  assign out_row        = out_valid ? row_q : '0;
  assign out_col        = out_valid ? col_q : '0;
  assign out_center     = out_valid & board_q[cur_idx];
  assign out_neighbours = out_valid ? nbr : 8'h00;
  assign out_last       = out_valid & at_end;

endmodule
